iobus_write_buffer: RTL and testbench

Posted-write FIFO between the OTTER MCU memory stage and slow memory-mapped peripherals. It captures every single-cycle `IOBUS_WR` strobe, with its address and data, into a small queue. It drains the queue to a peripheral port using a valid/ready handshake, so the pipeline never waits on a peripheral. Overflow is flagged rather than stalling the core.

---
 rtl/iobus_write_buffer.sv | 82 ++++++++
 tb/tb_iobus_write_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iobus_write_buffer.sv
// rtl/iobus_write_buffer.sv - posted-write FIFO between the memory stage and slow peripherals
module iobus_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [AW-1:0]              IOBUS_ADDR,
  input  logic [DW-1:0]              IOBUS_OUT,
  input  logic                       IOBUS_WR,
  input  logic                       OVF_CLR,
  input  logic                       PER_READY,
  output logic                       PER_VALID,
  output logic [AW-1:0]              PER_ADDR,
  output logic [DW-1:0]              PER_DATA,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          drop;

  assign FULL      = (count == CW'(DEPTH));
  assign EMPTY     = (count == '0);
  assign PER_VALID = !EMPTY;
  assign PER_ADDR  = addr_mem[rp];
  assign PER_DATA  = data_mem[rp];
  assign COUNT     = count;
  assign OVERFLOW  = ovf;

  // A pop frees the head slot this edge, so a full buffer may still accept a write
  assign pop  = PER_VALID & PER_READY;
  assign push = IOBUS_WR & (!FULL | pop);
  assign drop = IOBUS_WR & !push;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wp] <= IOBUS_ADDR;
        data_mem[wp] <= IOBUS_OUT;
        wp           <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // Setting wins over a same-cycle clear so no drop is ever lost
      if (drop) begin
        ovf <= 1'b1;
      end else if (OVF_CLR) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iobus_write_buffer.sv
// tb/tb_iobus_write_buffer.sv - self-checking bench for iobus_write_buffer
module tb_iobus_write_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic        OVF_CLR = 1'b0;
  logic        PER_READY = 1'b0;
  logic        PER_VALID;
  logic [31:0] PER_ADDR;
  logic [31:0] PER_DATA;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        EMPTY;
  logic        OVERFLOW;

  iobus_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .OVF_CLR(OVF_CLR), .PER_READY(PER_READY),
    .PER_VALID(PER_VALID), .PER_ADDR(PER_ADDR), .PER_DATA(PER_DATA),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of {addr,data} words plus the sticky drop flag
  logic [63:0] mq[$];
  logic [63:0] rx[$];
  logic        m_ovf = 1'b0;
  bit          cmp_en = 1'b0;
  int          max_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (!RESET_N) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && PER_READY;
      do_push = IOBUS_WR && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) rx.push_back(mq.pop_front());
      if (do_push) mq.push_back({IOBUS_ADDR, IOBUS_OUT});
      if (IOBUS_WR && !do_push) m_ovf = 1'b1;
      else if (OVF_CLR) m_ovf = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_valid", 64'(PER_VALID), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("cyc_head", {PER_ADDR, PER_DATA}, mq[0]);
      chk("cyc_count", 64'(COUNT), 64'(mq.size()));
      chk("cyc_full", 64'(FULL), 64'(mq.size() == DEPTH));
      chk("cyc_empty", 64'(EMPTY), 64'(mq.size() == 0));
      chk("cyc_ovf", 64'(OVERFLOW), 64'(m_ovf));
      if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_WR = 1'b1; IOBUS_ADDR = a; IOBUS_OUT = d;
    step();
    IOBUS_WR = 1'b0;
  endtask

  initial begin
    logic [63:0] head;
    repeat (2) step();
    chk("rst_valid", 64'(PER_VALID), 64'd0);
    chk("rst_empty", 64'(EMPTY), 64'd1);
    chk("rst_addr", 64'(PER_ADDR), 64'd0);
    RESET_N = 1'b1;
    cmp_en = 1'b1;
    step();

    // Single write latency
    wr(32'h1100_0040, 32'hDEAD_BEEF);
    chk("lat_valid", 64'(PER_VALID), 64'd1);
    chk("lat_addr", 64'(PER_ADDR), 64'h1100_0040);
    chk("lat_data", 64'(PER_DATA), 64'hDEAD_BEEF);
    chk("lat_count", 64'(COUNT), 64'd1);
    step(); step();
    PER_READY = 1'b1;
    step();
    PER_READY = 1'b0;
    chk("lat_empty", 64'(EMPTY), 64'd1);

    // Fill and overflow
    rx.delete();
    for (int i = 1; i <= 5; i++) wr(32'h2000_0000 + 32'(i), 32'(i));
    chk("ovf_full", 64'(FULL), 64'd1);
    chk("ovf_set", 64'(OVERFLOW), 64'd1);
    PER_READY = 1'b1;
    repeat (4) step();
    PER_READY = 1'b0;
    chk("ovf_rxn", 64'(rx.size()), 64'd4);
    for (int i = 0; i < 4 && i < rx.size(); i++) chk("ovf_order", 64'(rx[i][31:0]), 64'(i + 1));
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    chk("ovf_clr", 64'(OVERFLOW), 64'd0);

    // Push and pop while full
    rx.delete();
    for (int i = 0; i < 4; i++) wr(32'h3000_0000, 32'h10 + 32'(i));
    chk("pp_full", 64'(FULL), 64'd1);
    PER_READY = 1'b1;
    wr(32'h3000_0000, 32'hA5);
    chk("pp_count", 64'(COUNT), 64'd4);
    chk("pp_ovf", 64'(OVERFLOW), 64'd0);
    repeat (4) step();
    PER_READY = 1'b0;
    chk("pp_rxn", 64'(rx.size()), 64'd5);
    if (rx.size() == 5) chk("pp_last", 64'(rx[4][31:0]), 64'hA5);

    // Wrap-around streaming, one write every other cycle with READY toggling
    rx.delete();
    max_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      PER_READY = (c % 2 == 0);
      IOBUS_WR = (c % 2 == 0);
      IOBUS_ADDR = 32'h4000_0000 + 32'(c / 2);
      IOBUS_OUT = 32'(c / 2);
      step();
    end
    IOBUS_WR = 1'b0;
    PER_READY = 1'b1;
    repeat (4) step();
    chk("wr_rxn", 64'(rx.size()), 64'd20);
    for (int i = 0; i < rx.size(); i++) chk("wr_order", 64'(rx[i][31:0]), 64'(i));
    chk("wr_maxcnt", 64'(max_cnt <= DEPTH), 64'd1);
    chk("wr_ovf", 64'(OVERFLOW), 64'd0);

    // Back-to-back throughput with READY held high
    rx.delete();
    for (int i = 0; i < 8; i++) wr(32'h5000_0000, 32'h100 + 32'(i));
    step();
    chk("tp_rxn", 64'(rx.size()), 64'd8);
    chk("tp_ovf", 64'(OVERFLOW), 64'd0);
    PER_READY = 1'b0;

    // Head stability under backpressure
    wr(32'h6000_0004, 32'hCAFE_F00D);
    head = {PER_ADDR, PER_DATA};
    chk("hs_init", head, {32'h6000_0004, 32'hCAFE_F00D});
    for (int c = 0; c < 6; c++) begin
      IOBUS_WR = (c < 3);
      IOBUS_ADDR = 32'h6000_0008;
      IOBUS_OUT = 32'(c);
      step();
      chk("hs_stable", {PER_ADDR, PER_DATA}, {32'h6000_0004, 32'hCAFE_F00D});
    end
    IOBUS_WR = 1'b0;
    chk("hs_count", 64'(COUNT), 64'd4);

    // Asynchronous reset mid-drain with three entries queued
    PER_READY = 1'b1;
    step();
    PER_READY = 1'b0;
    chk("ar_pre", 64'(COUNT), 64'd3);
    #2;
    RESET_N = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    chk("ar_valid", 64'(PER_VALID), 64'd0);
    chk("ar_count", 64'(COUNT), 64'd0);
    chk("ar_empty", 64'(EMPTY), 64'd1);
    chk("ar_ovf", 64'(OVERFLOW), 64'd0);
    chk("ar_addr", 64'(PER_ADDR), 64'd0);
    step(); step();
    RESET_N = 1'b1;
    wr(32'h7000_0000, 32'h77);
    chk("ar_first", {PER_ADDR, PER_DATA}, {32'h7000_0000, 32'h77});
    step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
